// File: rtl/line_rotation_pkg.sv
// Shared constants and state type for the line rotator / derotator pair.
// Geometry is NTSC BT.656: 858 words x 2 per line, 1440 active samples.
package line_rotation_pkg;
  localparam int LINE_SIZE    = 1716;
  localparam int ACTIVE_START = 276;
  localparam int ACTIVE_LEN   = 1440;
  localparam int CUT_SHIFT    = 2;

  localparam logic [10:0] LAST_IDX  = 11'(LINE_SIZE - 1);
  localparam logic [10:0] ACT_START = 11'(ACTIVE_START);
  localparam logic [11:0] ACT_LEN   = 12'(ACTIVE_LEN);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  // Cut positions move in whole Cb-Y-Cr-Y groups.
  function automatic logic [10:0] cut_offset(input logic [7:0] raw);
    return 11'(raw) << CUT_SHIFT;
  endfunction
endpackage

// File: rtl/line_rotation_bank_ram.sv
// Ping-pong line store: two banks of LINE_SIZE x 10, bank bit selects the half.
// One write port, one registered read port.
module line_rotation_bank_ram
  import line_rotation_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic        wbank,
  input  logic [10:0] waddr,
  input  logic [9:0]  wdata,
  input  logic        rbank,
  input  logic [10:0] raddr,
  output logic [9:0]  rdata
);
  logic [9:0] mem [2][LINE_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
    rdata <= mem[rbank][raddr];
  end
endmodule

// File: rtl/line_derotator.sv
// Undoes the per-line active-video rotation: buffers one line and replays it
// one line later with each active sample fetched from its scrambled position.
module line_derotator
  import line_rotation_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       H,
  input  logic       V,
  input  logic [7:0] raw_cut_position,
  input  logic       cut_valid,
  output logic [9:0] data_out,
  output logic       data_out_valid,
  output logic       sync_error,
  output logic       cut_missing
);
  state_t      state;
  logic        h_prev, wbank, vline_next, vline_cur;
  logic [10:0] wi, off_next, off_cur;
  logic        h_rise, short_line, wb, we, out_ok;
  logic [10:0] wa, ra;
  logic [11:0] s_raw, s;
  logic [9:0]  ram_q;

  assign h_rise     = H & ~h_prev;
  assign short_line = h_rise && (state != IDLE) && (wi != LAST_IDX);
  assign wa         = h_rise ? 11'd0 : ((wi == LAST_IDX) ? wi : wi + 11'd1);
  assign wb         = h_rise ? ~wbank : wbank;
  assign we         = h_rise || (state != IDLE);
  assign out_ok     = (state == RUN) && !short_line;

  // Active sample m of the replayed line lives at scrambled index (m - off) mod ACTIVE_LEN.
  always_comb begin
    s_raw = {1'b0, wa} - {1'b0, ACT_START} + ACT_LEN - {1'b0, off_cur};
    s     = (s_raw >= ACT_LEN) ? s_raw - ACT_LEN : s_raw;
    if (wa < ACT_START || vline_cur || off_cur == 11'd0) ra = wa;
    else ra = 11'({1'b0, ACT_START} + s);
  end

  line_rotation_bank_ram u_ram (
    .clk   (clk),
    .we    (we),
    .wbank (wb),
    .waddr (wa),
    .wdata (data_in),
    .rbank (~wb),
    .raddr (ra),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      h_prev         <= H;
      wi             <= '0;
      wbank          <= 1'b0;
      off_next       <= '0;
      off_cur        <= '0;
      vline_next     <= 1'b0;
      vline_cur      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      sync_error     <= 1'b0;
      cut_missing    <= 1'b0;
    end else begin
      h_prev         <= H;
      wi             <= wa;
      wbank          <= wb;
      sync_error     <= short_line;
      data_out_valid <= out_ok;
      data_out       <= out_ok ? ram_q : '0;
      if (h_rise) begin
        off_next   <= (cut_valid && !V) ? cut_offset(raw_cut_position) : 11'd0;
        vline_next <= V;
        off_cur    <= off_next;
        vline_cur  <= vline_next;
        if (!V && !cut_valid) cut_missing <= 1'b1;
        case (state)
          IDLE:    state <= FILL;
          FILL:    state <= short_line ? FILL : RUN;
          RUN:     state <= short_line ? FILL : RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_line_derotator.sv
// Bench: generates original lines, scrambles them as the transmitter would,
// and expects the original samples back one line later.
module tb_line_derotator;
  import line_rotation_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] data_in = '0;
  logic       H = 1'b0, V = 1'b0, cut_valid = 1'b0;
  logic [7:0] raw_cut_position = '0;
  logic [9:0] data_out;
  logic       data_out_valid, sync_error, cut_missing;

  line_derotator dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .H                (H),
    .V                (V),
    .raw_cut_position (raw_cut_position),
    .cut_valid        (cut_valid),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .sync_error       (sync_error),
    .cut_missing      (cut_missing)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ecnt = 0, e_rise0 = 0, serr_pulses = 0;
  bit chk_en = 0, rise0_seen = 0, seen_v = 0;

  // model state: original samples of the line being received and of the previous one
  logic [9:0] m_cur  [LINE_SIZE];
  logic [9:0] m_prev [LINE_SIZE];
  int         m_mode = 0, m_pos = 0;
  bit         m_hp = 0, m_cm = 0, m_pend = 0;
  logic [9:0] m_pend_d = '0;
  bit         exp_vld = 0, exp_serr = 0, exp_cm = 0;
  logic [9:0] exp_dat = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 waiting for first line, 1 collecting a line, 2 replaying previous line
  task automatic model_step(input bit rst, input bit h, input bit v, input bit cv,
                            input logic [9:0] o);
    bit rise, serr;
    rise = h && !m_hp;
    m_hp = h;
    serr = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_cm = 0; m_pend = 0;
      exp_vld = 0; exp_dat = '0; exp_serr = 0; exp_cm = 0;
      return;
    end
    if (rise) begin
      if (m_mode == 0) begin
        m_mode = 1;
        if (!rise0_seen) begin rise0_seen = 1; e_rise0 = ecnt; end
      end else if (m_pos != LINE_SIZE - 1) begin
        serr = 1; m_mode = 1;
      end else begin
        m_mode = 2; m_prev = m_cur;
      end
      if (!v && !cv) m_cm = 1;
      m_pos = 0;
    end else if (m_pos < LINE_SIZE - 1) m_pos++;
    m_cur[m_pos] = o;
    exp_serr = serr;
    exp_cm   = m_cm;
    exp_vld  = m_pend && !serr;
    exp_dat  = m_pend_d;
    m_pend   = (m_mode == 2);
    m_pend_d = m_prev[m_pos];
  endtask

  task automatic tick(input bit rst, input bit h, input bit v, input logic [7:0] cp,
                      input bit cv, input logic [9:0] d, input logic [9:0] o);
    reset = rst; H = h; V = v; raw_cut_position = cp; cut_valid = cv; data_in = d;
    @(posedge clk); #1;
    ecnt++;
    model_step(rst, h, v, cv, o);
    chk_en = 1;
    if (rise0_seen && !seen_v && data_out_valid) begin
      seen_v = 1;
      chk("valid_latency", ecnt - e_rise0, 1717);
    end
  endtask

  // pat: 0 random, 1 ramp, 2 active samples carry their active index
  task automatic drive_line(input int len, input int cut, input bit cv, input bit v,
                            input int pat, input int rst_at, input bit lit_chk);
    logic [9:0] orig [LINE_SIZE];
    logic [9:0] scr  [LINE_SIZE];
    int off;
    for (int k = 0; k < len; k++)
      orig[k] = (pat == 1) ? 10'(k) : (pat == 2 && k >= ACTIVE_START) ?
                10'(k - ACTIVE_START) : 10'($urandom);
    scr = orig;
    off = (cv && !v) ? cut * 4 : 0;
    if (len == LINE_SIZE && off != 0)
      for (int j = 0; j < ACTIVE_LEN; j++)
        scr[ACTIVE_START + j] = orig[ACTIVE_START + (j + off) % ACTIVE_LEN];
    if (pat == 2 && off == 1020) chk("scramble_pin", int'(scr[ACTIVE_START]), 1020);
    for (int k = 0; k < len; k++) begin
      tick(k == rst_at, k < 4,
           (k == 0) ? v : 1'($urandom),
           (k == 0) ? 8'(cut) : 8'($urandom),
           (k == 0) ? cv : 1'($urandom),
           scr[k], orig[k]);
      if (k == rst_at) begin
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_cut_missing", int'(cut_missing), 0);
      end
      if (lit_chk && k == 277)  chk("wrap_first", int'(data_out), 0);
      if (lit_chk && k == 1277) chk("wrap_1000", int'(data_out), 1000);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", int'(data_out_valid), int'(exp_vld));
      if (exp_vld) chk("data", int'(data_out), int'(exp_dat));
      chk("sync_error", int'(sync_error), int'(exp_serr));
      chk("cut_missing", int'(cut_missing), int'(exp_cm));
      if (sync_error) serr_pulses++;
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 8'd0, 0, 10'd0, 10'd0);
    chk("reset_data", int'(data_out), 0);
    chk("reset_valid", int'(data_out_valid), 0);
    chk("reset_sync_error", int'(sync_error), 0);
    chk("reset_cut_missing", int'(cut_missing), 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'($urandom), 1'($urandom), 10'($urandom), 10'd0);
    // identity lines
    for (int i = 0; i < 3; i++) drive_line(LINE_SIZE, 0, 1, 0, 1, -1, 0);
    // fixed and random cuts
    drive_line(LINE_SIZE, 1, 1, 0, 0, -1, 0);
    drive_line(LINE_SIZE, 128, 1, 0, 0, -1, 0);
    drive_line(LINE_SIZE, 255, 1, 0, 0, -1, 0);
    for (int i = 0; i < 3; i++) drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, -1, 0);
    // wrap boundary, then the line that replays it
    drive_line(LINE_SIZE, 255, 1, 0, 2, -1, 0);
    drive_line(LINE_SIZE, int'($urandom_range(1, 255)), 1, 0, 0, -1, 1);
    // vertical blanking line with a cut offered
    drive_line(LINE_SIZE, 77, 1, 1, 0, -1, 0);
    drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, -1, 0);
    // missing cut
    drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 0, 0, 0, -1, 0);
    drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, -1, 0);
    // short line
    drive_line(1001, 9, 1, 0, 0, -1, 0);
    for (int i = 0; i < 3; i++) drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, -1, 0);
    // reset in the middle of a replayed line
    drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, 800, 0);
    for (int i = 0; i < 3; i++) drive_line(LINE_SIZE, int'($urandom_range(0, 255)), 1, 0, 0, -1, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 8'd0, 0, 10'd0, 10'd0);
    chk("saw_valid", int'(seen_v), 1);
    chk("sync_error_pulses", serr_pulses, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
